// File: rtl/types_pkg.sv
// Shared model-buffer and triangle types for the draw path, plus the
// model_reader state encoding so debug taps and benches agree on it.
package types_pkg;

  localparam int MB_MODEL_COUNT    = 10;
  localparam int MB_TRIANGLE_COUNT = 512;
  localparam int MB_IW             = $clog2(MB_MODEL_COUNT);
  localparam int MB_TW             = $clog2(MB_TRIANGLE_COUNT);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vertex_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;

  typedef struct packed {
    logic last;
  } triangle_meta_t;

  typedef struct packed {
    logic [MB_IW-1:0] model_index;
    logic [MB_TW-1:0] triangle_index;
  } modelbuf_read_t;

  typedef enum logic [1:0] {
    MR_IDLE  = 2'd0,
    MR_ISSUE = 2'd1,
    MR_DRAIN = 2'd2
  } model_reader_state_t;

endpackage

// File: rtl/model_reader.sv
// Streams one model's triangles from the model buffer into the transform pipeline.
// Define MODEL_READER_STATS_EN to add last_tri_count (triangles in the last finished model).
module model_reader
  import types_pkg::*;
#(
  parameter  int MAX_MODEL_COUNT    = 10,
  parameter  int MAX_TRIANGLE_COUNT = 512,
  localparam int IW                 = $clog2(MAX_MODEL_COUNT),
  localparam int TW                 = $clog2(MAX_TRIANGLE_COUNT)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [IW-1:0]  cmd_model_index,
  output logic           req_valid,
  input  logic           req_ready,
  output modelbuf_read_t req_data,
  input  logic           resp_valid,
  output logic           resp_ready,
  input  triangle_t      resp_data,
  input  triangle_meta_t resp_metadata,
  output logic           out_valid,
  input  logic           out_ready,
  output triangle_t      out_data,
  output logic           out_last,
  output logic           done,
  output logic           empty_model
`ifdef MODEL_READER_STATS_EN
  ,
  output logic [TW:0]    last_tri_count
`endif
);

  localparam logic [TW-1:0] LAST_TRI_IDX = TW'(MAX_TRIANGLE_COUNT - 1);

  model_reader_state_t state_q, state_d;
  logic [IW-1:0] model_idx_q, model_idx_d;
  logic [TW-1:0] tri_idx_q, tri_idx_d;
  logic pending_q, pending_d;
  logic emitted_q, emitted_d;
  logic done_q, done_d;
  logic empty_q, empty_d;

  logic out_fire;
  logic req_fire;
  logic term_last;
  logic term_missing;

  // Responses pass straight through; in IDLE they are swallowed so strays cannot stall the buffer.
  assign out_valid  = resp_valid && (state_q != MR_IDLE);
  assign resp_ready = out_ready || (state_q == MR_IDLE);
  assign out_data   = resp_data;
  assign out_last   = resp_metadata.last;

  assign cmd_ready   = (state_q == MR_IDLE);
  assign req_valid   = (state_q == MR_ISSUE);
  assign req_data    = '{model_index: model_idx_q, triangle_index: tri_idx_q};
  assign done        = done_q;
  assign empty_model = empty_q;

  assign out_fire     = out_valid && out_ready;
  assign req_fire     = req_valid && req_ready;
  assign term_last    = out_fire && out_last;
  // A request accepted last cycle must be answered now; silence means the index is past the model end.
  assign term_missing = pending_q && !resp_valid;

  always_comb begin
    state_d     = state_q;
    model_idx_d = model_idx_q;
    tri_idx_d   = tri_idx_q;
    pending_d   = req_fire;
    emitted_d   = emitted_q || out_fire;
    done_d      = 1'b0;
    empty_d     = 1'b0;

    unique case (state_q)
      MR_IDLE: begin
        if (cmd_valid) begin
          model_idx_d = cmd_model_index;
          tri_idx_d   = '0;
          emitted_d   = 1'b0;
          state_d     = MR_ISSUE;
        end
      end
      MR_ISSUE: begin
        if (req_fire) begin
          if (tri_idx_q == LAST_TRI_IDX) begin
            state_d = MR_DRAIN;
          end else begin
            tri_idx_d = tri_idx_q + 1'b1;
          end
        end
      end
      MR_DRAIN: begin
        state_d = MR_DRAIN;
      end
      default: begin
        state_d = MR_IDLE;
      end
    endcase

    // out_last beats a missing response if both ever coincide.
    if (state_q != MR_IDLE) begin
      if (term_last) begin
        done_d    = 1'b1;
        pending_d = 1'b0;
        state_d   = MR_IDLE;
      end else if (term_missing) begin
        done_d    = 1'b1;
        empty_d   = !emitted_q;
        pending_d = 1'b0;
        state_d   = MR_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= MR_IDLE;
      model_idx_q <= '0;
      tri_idx_q   <= '0;
      pending_q   <= 1'b0;
      emitted_q   <= 1'b0;
      done_q      <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      model_idx_q <= model_idx_d;
      tri_idx_q   <= tri_idx_d;
      pending_q   <= pending_d;
      emitted_q   <= emitted_d;
      done_q      <= done_d;
      empty_q     <= empty_d;
    end
  end

`ifdef MODEL_READER_STATS_EN
  localparam int CW = TW + 1;

  logic [TW:0] tri_count_q, tri_count_d;
  logic [TW:0] last_tri_count_q, last_tri_count_d;

  // The running count includes the handshake of the terminating cycle itself.
  always_comb begin
    tri_count_d      = tri_count_q + CW'(out_fire);
    last_tri_count_d = last_tri_count_q;
    if (state_q == MR_IDLE) begin
      tri_count_d = '0;
    end
    if (done_d) begin
      last_tri_count_d = tri_count_q + CW'(out_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tri_count_q      <= '0;
      last_tri_count_q <= '0;
    end else begin
      tri_count_q      <= tri_count_d;
      last_tri_count_q <= last_tri_count_d;
    end
  end

  assign last_tri_count = last_tri_count_q;
`endif

endmodule

// File: tb/tb_model_reader.sv
// Directed bench for model_reader with a behavioural model buffer that answers
// one cycle after acceptance and discards requests beyond a model's size.
module tb_model_reader;
  import types_pkg::*;

  localparam int IW = MB_IW;
  localparam int TW = MB_TW;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [IW-1:0]  cmd_model_index = '0;
  logic           req_valid;
  logic           req_ready;
  modelbuf_read_t req_data;
  logic           resp_valid = 1'b0;
  logic           resp_ready;
  triangle_t      resp_data = '0;
  triangle_meta_t resp_metadata = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  triangle_t      out_data;
  logic           out_last;
  logic           done;
  logic           empty_model;
`ifdef MODEL_READER_STATS_EN
  logic [TW:0]    last_tri_count;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sizes [16];

  triangle_t      out_q [$];
  logic           last_q [$];
  int             out_cyc [$];
  modelbuf_read_t req_q [$];
  int             acc_cyc [$];
  int             done_cyc [$];
  int             empty_cyc [$];
  int             done_cnt = 0;
  int             empty_cnt = 0;

  always #5 clk = ~clk;

  model_reader #(
    .MAX_MODEL_COUNT   (10),
    .MAX_TRIANGLE_COUNT(512)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_model_index(cmd_model_index),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_metadata  (resp_metadata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .done           (done),
    .empty_model    (empty_model)
`ifdef MODEL_READER_STATS_EN
    ,
    .last_tri_count (last_tri_count)
`endif
  );

  function automatic triangle_t mk_tri(input int m, input int i);
    triangle_t t;
    t.v0 = '{x: 16'(m), y: 16'(i), z: 16'h00A0};
    t.v1 = '{x: 16'(i + 256), y: 16'(m + 512), z: 16'h0B1B};
    t.v2 = '{x: 16'(m * 64 + i), y: 16'hC0DE, z: 16'(i) ^ 16'h5A5A};
    return t;
  endfunction

  function automatic modelbuf_read_t mk_req(input int m, input int i);
    modelbuf_read_t r;
    r.model_index    = IW'(m);
    r.triangle_index = TW'(i);
    return r;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Model buffer: one-slot output register, so it only takes a request when that slot frees up.
  assign req_ready = !resp_valid || resp_ready;

  always @(posedge clk) begin
    if (!rstn) begin
      resp_valid <= 1'b0;
    end else if (req_valid && req_ready &&
                 int'(req_data.triangle_index) < sizes[req_data.model_index]) begin
      resp_valid    <= 1'b1;
      resp_data     <= mk_tri(int'(req_data.model_index), int'(req_data.triangle_index));
      resp_metadata <= '{last: (int'(req_data.triangle_index) == sizes[req_data.model_index] - 1)};
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle; the directed sequence inspects it after the following edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      last_q.push_back(out_last);
      out_cyc.push_back(cyc);
    end
    if (req_valid && req_ready) req_q.push_back(req_data);
    if (cmd_valid && cmd_ready) acc_cyc.push_back(cyc);
    if (done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    if (empty_model) begin
      empty_cnt++;
      empty_cyc.push_back(cyc);
    end
  end

  task automatic check_output(input string tag, input logic [159:0] observed,
                              input logic [159:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    out_q.delete();
    last_q.delete();
    out_cyc.delete();
    req_q.delete();
    acc_cyc.delete();
    done_cyc.delete();
    empty_cyc.delete();
    done_cnt  = 0;
    empty_cnt = 0;
  endtask

  task automatic start_cmd(input int m, input string tag);
    int n0 = acc_cyc.size();
    cmd_valid       = 1'b1;
    cmd_model_index = IW'(m);
    for (int w = 0; w < 20 && acc_cyc.size() == n0; w++) tick();
    cmd_valid = 1'b0;
    check_output(tag, acc_cyc.size() > n0, 1);
  endtask

  task automatic wait_done(input int n, input int bound, input string tag);
    for (int w = 0; w < bound && done_cnt < n; w++) tick();
    check_output(tag, done_cnt >= n, 1);
  endtask

  task automatic check_stream(input string tag, input int m, input int n);
    check_output({tag, "_count"}, out_q.size(), n);
    for (int i = 0; i < out_q.size() && i < n; i++) begin
      check_output({tag, "_data"}, out_q[i], mk_tri(m, i));
      check_output({tag, "_last"}, last_q[i], (i == n - 1));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic      stalled;
    triangle_t held;
    int        nlast;

    foreach (sizes[i]) sizes[i] = 0;
    sizes[1] = 2;
    sizes[2] = 3;
    sizes[3] = 1;
    sizes[4] = 4;
    sizes[6] = 5;
    sizes[7] = 3;

    // Reset values
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_cmd_ready", cmd_ready, 1);
    check_output("rst_req_valid", req_valid, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_done", done, 0);
    check_output("rst_empty", empty_model, 0);
`ifdef MODEL_READER_STATS_EN
    check_output("rst_last_tri_count", last_tri_count, 0);
`endif
    tick();
    rstn = 1'b1;
    tick();

    // Model 2, three triangles, everything ready
    clear_logs();
    start_cmd(2, "t1_accept");
    check_output("t1_cmd_ready_busy", cmd_ready, 0);
    check_output("t1_req_valid_busy", req_valid, 1);
    wait_done(1, 40, "t1_done_seen");
    repeat (3) tick();
    check_stream("t1", 2, 3);
    check_output("t1_first_latency", qget(out_cyc, 0) - qget(acc_cyc, 0), 2);
    check_output("t1_back_to_back", qget(out_cyc, 2) - qget(out_cyc, 0), 2);
    check_output("t1_done_after_last", qget(done_cyc, 0) - qget(out_cyc, 2), 1);
    check_output("t1_done_pulses", done_cnt, 1);
    check_output("t1_empty_pulses", empty_cnt, 0);
    check_output("t1_req_count", req_q.size(), 4);
    if (req_q.size() >= 4) check_output("t1_req_overrun", req_q[3], mk_req(2, 3));

    // Model 5, unwritten
    clear_logs();
    start_cmd(5, "t2_accept");
    wait_done(1, 20, "t2_done_seen");
    repeat (3) tick();
    check_output("t2_out_count", out_q.size(), 0);
    check_output("t2_done_pulses", done_cnt, 1);
    check_output("t2_empty_pulses", empty_cnt, 1);
    check_output("t2_done_latency", qget(done_cyc, 0) - qget(acc_cyc, 0), 3);
    check_output("t2_empty_with_done", qget(empty_cyc, 0), qget(done_cyc, 0));
    if (req_q.size() >= 1) check_output("t2_req0", req_q[0], mk_req(5, 0));

    // Model 4 with out_ready pattern 1,0,0 repeating
    clear_logs();
    stalled         = 1'b0;
    held            = '0;
    cmd_valid       = 1'b1;
    cmd_model_index = IW'(4);
    for (int k = 0; k < 80; k++) begin
      if (done_cnt != 0) break;
      if (acc_cyc.size() > 0) cmd_valid = 1'b0;
      out_ready = (k % 3 == 0);
      @(negedge clk);
      if (stalled && out_valid) check_output("t3_hold_data", out_data, held);
      if (k == 2) check_output("t3_cmd_ready_busy", cmd_ready, 0);
      stalled = out_valid && !out_ready;
      held    = out_data;
      tick();
    end
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    check_output("t3_done_seen", done_cnt, 1);
    repeat (2) tick();
    check_stream("t3", 4, 4);
    nlast = 0;
    foreach (last_q[i]) nlast += int'(last_q[i]);
    check_output("t3_single_last", nlast, 1);
    check_output("t3_empty_pulses", empty_cnt, 0);

    // cmd_valid held across models 1 then 3
    clear_logs();
    cmd_valid       = 1'b1;
    cmd_model_index = IW'(1);
    for (int w = 0; w < 20 && acc_cyc.size() < 1; w++) tick();
    cmd_model_index = IW'(3);
    for (int w = 0; w < 40 && acc_cyc.size() < 2; w++) tick();
    cmd_valid = 1'b0;
    check_output("t4_two_accepts", acc_cyc.size(), 2);
    wait_done(2, 20, "t4_done_seen");
    repeat (3) tick();
    check_output("t4_second_accept_at_done", qget(acc_cyc, 1), qget(done_cyc, 0));
    check_output("t4_accept_spacing", qget(acc_cyc, 1) - qget(acc_cyc, 0), 4);
    check_output("t4_count", out_q.size(), 3);
    if (out_q.size() >= 3) begin
      check_output("t4_data0", out_q[0], mk_tri(1, 0));
      check_output("t4_data1", out_q[1], mk_tri(1, 1));
      check_output("t4_data2", out_q[2], mk_tri(3, 0));
      check_output("t4_lasts", {last_q[0], last_q[1], last_q[2]}, 3'b011);
    end
    check_output("t4_done_pulses", done_cnt, 2);

    // Reset in the middle of model 6
    clear_logs();
    start_cmd(6, "t5_accept");
    for (int w = 0; w < 10 && out_q.size() < 1; w++) tick();
    rstn = 1'b0;
    tick();
    @(negedge clk);
    check_output("t5_rst_out_valid", out_valid, 0);
    check_output("t5_rst_cmd_ready", cmd_ready, 1);
    check_output("t5_rst_req_valid", req_valid, 0);
    check_output("t5_rst_done", done, 0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    repeat (4) tick();
    check_output("t5_no_done", done_cnt, 0);
    check_output("t5_partial_count", out_q.size(), 2);
    clear_logs();
    start_cmd(6, "t5_restart_accept");
    wait_done(1, 40, "t5_done_seen");
    repeat (3) tick();
    if (req_q.size() >= 1) check_output("t5_restart_req0", req_q[0], mk_req(6, 0));
    check_stream("t5", 6, 5);
    check_output("t5_empty_pulses", empty_cnt, 0);
`ifdef MODEL_READER_STATS_EN
    check_output("t5_last_tri_count", last_tri_count, 5);

    // Statistics latch and hold
    clear_logs();
    start_cmd(7, "t6_accept");
    wait_done(1, 40, "t6_done_seen");
    check_output("t6_count_after_done", last_tri_count, 3);
    repeat (6) tick();
    check_output("t6_count_idle_hold", last_tri_count, 3);
    check_output("t6_idle", cmd_ready, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
